// File: rtl/dm_pkg.sv
// Debug-module shared types: DMI request/response payloads and the DMI source tag
// used to route responses back to the master that issued the request.
package dm;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic {
    DmiSrcJtag = 1'b0,
    DmiSrcSys  = 1'b1
  } dmi_src_e;

endpackage

// File: rtl/dmi_arb_id_fifo.sv
// Source-ID FIFO: remembers which master issued each outstanding DMI request so
// the in-order DM responses can be steered back. Depth must be a power of two.
module dmi_arb_id_fifo
  import dm::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  dmi_src_e push_id_i,
  input  logic     pop_i,
  output dmi_src_e head_id_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  dmi_src_e        mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o    = (count_q == CntW'(Depth));
  assign empty_o   = (count_q == '0);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign head_id_o = mem_q[rd_ptr_q];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dmi_arb.sv
// Two-master DMI arbiter (JTAG DTM and system debug master) in front of the debug
// module: round-robin with grant lock on stalls, responses routed by source-ID FIFO.
module dmi_arb
  import dm::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  dmi_req_t  m0_req_i,
  input  logic      m0_req_valid_i,
  output logic      m0_req_ready_o,
  output dmi_resp_t m0_resp_o,
  output logic      m0_resp_valid_o,
  input  logic      m0_resp_ready_i,
  input  dmi_req_t  m1_req_i,
  input  logic      m1_req_valid_i,
  output logic      m1_req_ready_o,
  output dmi_resp_t m1_resp_o,
  output logic      m1_resp_valid_o,
  input  logic      m1_resp_ready_i,
  output dmi_req_t  dmi_req_o,
  output logic      dmi_req_valid_o,
  input  logic      dmi_req_ready_i,
  input  dmi_resp_t dmi_resp_i,
  input  logic      dmi_resp_valid_i,
  output logic      dmi_resp_ready_o,
  output logic      spurious_resp_o
);

  dmi_src_e rr_q;
  dmi_src_e lock_id_q;
  logic     lock_q;
  logic     spurious_q;
  dmi_src_e grant;
  logic     grant_valid;
  logic     accept;
  logic     pop;
  logic     fifo_full;
  logic     fifo_empty;
  dmi_src_e head_id;

  // A stalled grant stays locked so a waiting request cannot be pre-empted.
  always_comb begin
    grant = DmiSrcJtag;
    if (lock_q) begin
      grant = lock_id_q;
    end else if (m0_req_valid_i && m1_req_valid_i) begin
      grant = rr_q;
    end else if (m1_req_valid_i) begin
      grant = DmiSrcSys;
    end
  end

  assign grant_valid     = (grant == DmiSrcSys) ? m1_req_valid_i : m0_req_valid_i;
  assign dmi_req_o       = (grant == DmiSrcSys) ? m1_req_i : m0_req_i;
  assign dmi_req_valid_o = grant_valid && !fifo_full;
  assign accept          = dmi_req_valid_o && dmi_req_ready_i;
  assign m0_req_ready_o  = (grant == DmiSrcJtag) && dmi_req_ready_i && !fifo_full;
  assign m1_req_ready_o  = (grant == DmiSrcSys) && dmi_req_ready_i && !fifo_full;

  assign m0_resp_o        = dmi_resp_i;
  assign m1_resp_o        = dmi_resp_i;
  assign m0_resp_valid_o  = !fifo_empty && (head_id == DmiSrcJtag) && dmi_resp_valid_i;
  assign m1_resp_valid_o  = !fifo_empty && (head_id == DmiSrcSys) && dmi_resp_valid_i;
  // With nothing outstanding, drain whatever the DM sends so it cannot wedge.
  assign dmi_resp_ready_o = fifo_empty ? 1'b1
                          : ((head_id == DmiSrcSys) ? m1_resp_ready_i : m0_resp_ready_i);
  assign pop              = !fifo_empty && dmi_resp_valid_i && dmi_resp_ready_o;
  assign spurious_resp_o  = spurious_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= DmiSrcJtag;
      lock_q     <= 1'b0;
      lock_id_q  <= DmiSrcJtag;
      spurious_q <= 1'b0;
    end else begin
      if (accept) begin
        rr_q <= (grant == DmiSrcSys) ? DmiSrcJtag : DmiSrcSys;
      end
      lock_q <= grant_valid && !accept;
      if (grant_valid && !accept) begin
        lock_id_q <= grant;
      end
      spurious_q <= fifo_empty && dmi_resp_valid_i;
    end
  end

  dmi_arb_id_fifo #(
    .Depth(MaxOutstanding)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (accept),
    .push_id_i (grant),
    .pop_i     (pop),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_dmi_arb.sv
// Bench for dmi_arb: directed per-cycle vector table, reset corner sequence, and
// randomized traffic against a queue-based reference model.
module tb_dmi_arb;
  import dm::*;

  localparam int MAXO = 2;
  localparam int NV   = 22;

  logic      clk_i = 1'b0;
  logic      rst_ni;
  dmi_req_t  m0_req_i, m1_req_i, dmi_req_o;
  logic      m0_req_valid_i, m0_req_ready_o, m0_resp_valid_o, m0_resp_ready_i;
  logic      m1_req_valid_i, m1_req_ready_o, m1_resp_valid_o, m1_resp_ready_i;
  dmi_resp_t m0_resp_o, m1_resp_o, dmi_resp_i;
  logic      dmi_req_valid_o, dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_ready_o;
  logic      spurious_resp_o;

  always #5 clk_i = ~clk_i;

  dmi_arb #(.MaxOutstanding(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
    .m0_resp_o(m0_resp_o), .m0_resp_valid_o(m0_resp_valid_o), .m0_resp_ready_i(m0_resp_ready_i),
    .m1_req_i(m1_req_i), .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
    .m1_resp_o(m1_resp_o), .m1_resp_valid_o(m1_resp_valid_o), .m1_resp_ready_i(m1_resp_ready_i),
    .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_resp_i(dmi_resp_i), .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
    .spurious_resp_o(spurious_resp_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        m0v, m1v, dr, rv;
    logic [31:0] rd;
    logic        r0, r1;
    logic        e_m0r, e_m1r, e_dv;
    logic [6:0]  e_addr;
    logic        e_m0rv, e_m1rv, e_drr, e_sp;
  } vec_t;

  function automatic vec_t mk(input logic m0v, m1v, dr, rv, input logic [31:0] rd,
                              input logic r0, r1, e_m0r, e_m1r, e_dv,
                              input logic [6:0] e_addr,
                              input logic e_m0rv, e_m1rv, e_drr, e_sp);
    vec_t v;
    v.m0v = m0v; v.m1v = m1v; v.dr = dr; v.rv = rv; v.rd = rd; v.r0 = r0; v.r1 = r1;
    v.e_m0r = e_m0r; v.e_m1r = e_m1r; v.e_dv = e_dv; v.e_addr = e_addr;
    v.e_m0rv = e_m0rv; v.e_m1rv = e_m1rv; v.e_drr = e_drr; v.e_sp = e_sp;
    return v;
  endfunction

  vec_t vecs [NV];

  task automatic drive(input logic m0v, m1v, dr, rv, input logic [31:0] rd, input logic r0, r1);
    m0_req_valid_i   = m0v;
    m1_req_valid_i   = m1v;
    dmi_req_ready_i  = dr;
    dmi_resp_valid_i = rv;
    dmi_resp_i       = '{data: rd, resp: 2'd0};
    m0_resp_ready_i  = r0;
    m1_resp_ready_i  = r1;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model state
  bit       p0, p1;
  dmi_req_t q0, q1;
  bit       mrr, mlock, mlock_id, exp_sp;
  bit       ids [$];

  task automatic rand_cycle(input int n);
    bit       g, gv, full, acc, pop, empty, h, rdy;
    dmi_req_t greq;
    if (!p0 && $urandom_range(0, 2) == 0) begin
      p0 = 1'b1;
      q0 = dmi_req_t'({$urandom_range(0, 127), $urandom_range(0, 3), $urandom});
    end
    if (!p1 && $urandom_range(0, 2) == 0) begin
      p1 = 1'b1;
      q1 = dmi_req_t'({$urandom_range(0, 127), $urandom_range(0, 3), $urandom});
    end
    m0_req_i = q0;
    m1_req_i = q1;
    drive(p0, p1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    g     = mlock ? mlock_id : ((p0 && p1) ? mrr : p1);
    gv    = g ? p1 : p0;
    greq  = g ? q1 : q0;
    full  = (ids.size() == MAXO);
    empty = (ids.size() == 0);
    acc   = gv && !full && dmi_req_ready_i;
    h     = empty ? 1'b0 : ids[0];
    rdy   = empty ? 1'b1 : (h ? m1_resp_ready_i : m0_resp_ready_i);
    pop   = !empty && dmi_resp_valid_i && rdy;

    @(negedge clk_i);
    chk("rnd_req_valid", 64'(dmi_req_valid_o), 64'(gv && !full));
    if (gv && !full) chk("rnd_req_bus", 64'(dmi_req_o), 64'(greq));
    if (p0 || p1) begin
      chk("rnd_m0_ready", 64'(m0_req_ready_o), 64'(!g && dmi_req_ready_i && !full));
      chk("rnd_m1_ready", 64'(m1_req_ready_o), 64'(g && dmi_req_ready_i && !full));
    end
    chk("rnd_m0_rvalid", 64'(m0_resp_valid_o), 64'(!empty && !h && dmi_resp_valid_i));
    chk("rnd_m1_rvalid", 64'(m1_resp_valid_o), 64'(!empty && h && dmi_resp_valid_i));
    chk("rnd_resp_ready", 64'(dmi_resp_ready_o), 64'(rdy));
    chk("rnd_resp_bus", 64'({m0_resp_o, m1_resp_o}), 64'({dmi_resp_i, dmi_resp_i}));
    chk("rnd_spurious", 64'(spurious_resp_o), 64'(exp_sp));

    if (pop) void'(ids.pop_front());
    if (acc) begin
      ids.push_back(g);
      mrr = !g;
      if (g) p1 = 1'b0; else p0 = 1'b0;
      $display("rnd cycle %0d: accept m%0d addr 0x%0h outstanding %0d", n, g, greq.addr, ids.size());
    end
    mlock    = gv && !acc;
    mlock_id = g;
    exp_sp   = empty && dmi_resp_valid_i;
    next_cycle();
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 32'h0, 1, 1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rst_m0_ready", 64'(m0_req_ready_o), 64'(0));
    chk("rst_m1_ready", 64'(m1_req_ready_o), 64'(0));
    chk("rst_req_valid", 64'(dmi_req_valid_o), 64'(0));
    chk("rst_rvalids", 64'({m0_resp_valid_o, m1_resp_valid_o}), 64'(0));
    chk("rst_spurious", 64'(spurious_resp_o), 64'(0));
    next_cycle();
    rst_ni = 1'b1;
    p0 = 0; p1 = 0; mrr = 0; mlock = 0; mlock_id = 0; exp_sp = 0;
    ids.delete();
  endtask

  initial begin
    //            m0v m1v dr rv rd            r0 r1  m0r m1r dv addr   m0rv m1rv drr sp
    vecs[0]  = mk(0, 0, 0, 0, 32'h0,        1, 1,  0, 0, 0, 7'h00, 0, 0, 1, 0);
    vecs[1]  = mk(1, 0, 1, 0, 32'h0,        1, 1,  1, 0, 1, 7'h11, 0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 1, 32'hDEADBEEF, 1, 1,  0, 0, 0, 7'h00, 1, 0, 1, 0);
    vecs[3]  = mk(1, 1, 1, 0, 32'h0,        1, 1,  0, 1, 1, 7'h22, 0, 0, 1, 0);
    vecs[4]  = mk(1, 1, 1, 1, 32'h1,        1, 1,  1, 0, 1, 7'h11, 0, 1, 1, 0);
    vecs[5]  = mk(1, 1, 1, 1, 32'h2,        1, 1,  0, 1, 1, 7'h22, 1, 0, 1, 0);
    vecs[6]  = mk(1, 1, 1, 1, 32'h3,        1, 1,  1, 0, 1, 7'h11, 0, 1, 1, 0);
    vecs[7]  = mk(0, 1, 1, 1, 32'h4,        1, 1,  0, 1, 1, 7'h22, 1, 0, 1, 0);
    vecs[8]  = mk(0, 1, 0, 1, 32'h5,        1, 1,  0, 0, 1, 7'h22, 0, 1, 1, 0);
    vecs[9]  = mk(1, 1, 0, 0, 32'h0,        1, 1,  0, 0, 1, 7'h22, 0, 0, 1, 0);
    vecs[10] = mk(1, 1, 0, 0, 32'h0,        1, 1,  0, 0, 1, 7'h22, 0, 0, 1, 0);
    vecs[11] = mk(1, 1, 1, 0, 32'h0,        1, 1,  0, 1, 1, 7'h22, 0, 0, 1, 0);
    vecs[12] = mk(1, 0, 1, 0, 32'h0,        1, 1,  1, 0, 1, 7'h11, 0, 0, 1, 0);
    vecs[13] = mk(1, 0, 1, 1, 32'h6,        1, 0,  0, 0, 0, 7'h00, 0, 1, 0, 0);
    vecs[14] = mk(1, 0, 1, 1, 32'h6,        1, 0,  0, 0, 0, 7'h00, 0, 1, 0, 0);
    vecs[15] = mk(1, 0, 1, 1, 32'h6,        1, 1,  0, 0, 0, 7'h00, 0, 1, 1, 0);
    vecs[16] = mk(1, 0, 1, 0, 32'h0,        1, 1,  1, 0, 1, 7'h11, 0, 0, 1, 0);
    vecs[17] = mk(0, 0, 0, 1, 32'h7,        1, 1,  0, 0, 0, 7'h00, 1, 0, 1, 0);
    vecs[18] = mk(0, 0, 0, 1, 32'h8,        1, 1,  0, 0, 0, 7'h00, 1, 0, 1, 0);
    vecs[19] = mk(0, 0, 0, 1, 32'h9,        1, 1,  0, 0, 0, 7'h00, 0, 0, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 32'h0,        1, 1,  0, 0, 0, 7'h00, 0, 0, 1, 1);
    vecs[21] = mk(0, 0, 0, 0, 32'h0,        1, 1,  0, 0, 0, 7'h00, 0, 0, 1, 0);

    m0_req_i = '{addr: 7'h11, op: 2'd1, data: 32'h0};
    m1_req_i = '{addr: 7'h22, op: 2'd2, data: 32'h0000CAFE};
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 1, 1);
    repeat (2) next_cycle();
    apply_reset();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].m0v, vecs[i].m1v, vecs[i].dr, vecs[i].rv, vecs[i].rd, vecs[i].r0, vecs[i].r1);
      @(negedge clk_i);
      $display("vec %0d: m0v=%0d m1v=%0d dr=%0d rv=%0d", i, vecs[i].m0v, vecs[i].m1v, vecs[i].dr, vecs[i].rv);
      chk($sformatf("v%0d_m0_ready", i), 64'(m0_req_ready_o), 64'(vecs[i].e_m0r));
      chk($sformatf("v%0d_m1_ready", i), 64'(m1_req_ready_o), 64'(vecs[i].e_m1r));
      chk($sformatf("v%0d_req_valid", i), 64'(dmi_req_valid_o), 64'(vecs[i].e_dv));
      if (vecs[i].e_dv) chk($sformatf("v%0d_req_addr", i), 64'(dmi_req_o.addr), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d_m0_rvalid", i), 64'(m0_resp_valid_o), 64'(vecs[i].e_m0rv));
      chk($sformatf("v%0d_m1_rvalid", i), 64'(m1_resp_valid_o), 64'(vecs[i].e_m1rv));
      chk($sformatf("v%0d_resp_ready", i), 64'(dmi_resp_ready_o), 64'(vecs[i].e_drr));
      chk($sformatf("v%0d_spurious", i), 64'(spurious_resp_o), 64'(vecs[i].e_sp));
      if (vecs[i].rv) chk($sformatf("v%0d_resp_data", i), 64'(m0_resp_o.data), 64'(vecs[i].rd));
      next_cycle();
    end

    // Fill the FIFO, reset with two outstanding, then a late response is spurious.
    drive(1, 1, 1, 0, 32'h0, 1, 1);
    @(negedge clk_i);
    chk("seq_m1_first", 64'(m1_req_ready_o), 64'(1));
    next_cycle();
    drive(1, 0, 1, 0, 32'h0, 1, 1);
    @(negedge clk_i);
    chk("seq_m0_second", 64'(m0_req_ready_o), 64'(1));
    next_cycle();
    @(negedge clk_i);
    chk("seq_full_block", 64'({m0_req_ready_o, dmi_req_valid_o}), 64'(0));
    $display("seq: two outstanding, asserting reset");
    next_cycle();
    apply_reset();
    drive(0, 0, 0, 1, 32'h55, 1, 1);
    @(negedge clk_i);
    chk("seq_post_rst_rvalid", 64'({m0_resp_valid_o, m1_resp_valid_o}), 64'(0));
    chk("seq_post_rst_drain", 64'(dmi_resp_ready_o), 64'(1));
    next_cycle();
    drive(0, 0, 0, 0, 32'h0, 1, 1);
    @(negedge clk_i);
    chk("seq_spurious_pulse", 64'(spurious_resp_o), 64'(1));
    next_cycle();
    @(negedge clk_i);
    chk("seq_spurious_clear", 64'(spurious_resp_o), 64'(0));
    next_cycle();

    apply_reset();
    for (int n = 0; n < 600; n++) rand_cycle(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmi_arb.md
Name: dmi_arb

Overview:
- Core-clock-domain DMI arbiter between the JTAG DTM's core side and the debug module (dm_top).
- Merges two DMI masters onto one DMI slave: m0 = JTAG DTM (via dmi_cdc core side), m1 = secondary system-bus debug master.
- Tracks the source of every accepted request and steers each in-order DM response back to the master that issued it.

Parameters:
- MaxOutstanding, 2, depth of the source-ID FIFO, i.e. max requests accepted but not yet answered; power of two, >= 2.

Ports:
- clk_i  in  1  DMI/core clock
- rst_ni  in  1  asynchronous reset, active low
- m0_req_i  in  dm::dmi_req_t (41)  JTAG master request {addr[6:0], op[1:0], data[31:0]}
- m0_req_valid_i  in  1  JTAG request valid
- m0_req_ready_o  out  1  JTAG request accepted
- m0_resp_o  out  dm::dmi_resp_t (34)  JTAG response {data[31:0], resp[1:0]}
- m0_resp_valid_o  out  1  JTAG response valid
- m0_resp_ready_i  in  1  JTAG response ready
- m1_req_i, m1_req_valid_i, m1_req_ready_o, m1_resp_o, m1_resp_valid_o, m1_resp_ready_i  same as m0, for the system master
- dmi_req_o  out  dm::dmi_req_t (41)  request to DM
- dmi_req_valid_o  out  1  request valid to DM
- dmi_req_ready_i  in  1  DM accepts request
- dmi_resp_i  in  dm::dmi_resp_t (34)  response from DM
- dmi_resp_valid_i  in  1  DM response valid
- dmi_resp_ready_o  out  1  ready toward DM
- spurious_resp_o  out  1  one-cycle pulse when a DM response arrives with no request outstanding

Behaviour:
- Reset: all valid/ready outputs 0, spurious_resp_o 0, FIFO empty, RR pointer = m0, lock cleared. Reset mid-transaction discards all outstanding IDs; responses arriving afterwards are treated as spurious.
- Request path is zero-latency combinational: dmi_req_o/dmi_req_valid_o = the granted master's req/valid, gated by !fifo_full.
- Accept: handshake = dmi_req_valid_o && dmi_req_ready_i. Only the granted master's ready_o follows dmi_req_ready_i && !fifo_full; the other ready_o = 0.
- Arbitration:
  - Round-robin. With both valid and unlocked, grant the master the RR pointer names.
  - On each accept, the RR pointer moves to the other master.
  - With one valid, grant it regardless of the pointer.
- Lock: if the granted master is valid but not accepted (DM not ready or FIFO full), register lock_q=1 and lock_id_q. The grant holds on that master until its handshake, even if the other master asserts valid. The lock clears on handshake.
- ID FIFO: each accepted request pushes its source ID (0/1). Every op, including NOP, consumes exactly one DM response. A full FIFO blocks accepts; there is no same-cycle push-through when full. Pointers wrap modulo MaxOutstanding; the count is $clog2(MaxOutstanding)+1 bits.
- Response path, FIFO non-empty:
  - Head ID h selects the master: mh_resp_valid_o = dmi_resp_valid_i, other resp_valid_o = 0.
  - Both resp_o buses carry dmi_resp_i.
  - dmi_resp_ready_o = mh_resp_ready_i.
  - Pop on dmi_resp_valid_i && dmi_resp_ready_o.
- Response path, FIFO empty: dmi_resp_ready_o = 1 (drain). Both m*_resp_valid_o = 0. spurious_resp_o = dmi_resp_valid_i, registered for one cycle. The response is dropped.
- Same-cycle push and pop: both occur; count unchanged.
- DM ordering: responses are in request order. The block does not reorder and never consults addr/op.

Decomposition:
- Add typedef dmi_src_e {DmiSrcJtag=1'b0, DmiSrcSys=1'b1} to the dm package; dmi_req_t/dmi_resp_t already live there.
- One sub-module: dmi_arb_id_fifo, a single-clock FIFO of dmi_src_e, parameterized depth, with full/empty/push/pop ports.
- The arbiter and lock logic stay in dmi_arb.

Test Plan:
- m0 read addr 0x11, DM ready, response data 0xDEADBEEF resp 0 one cycle later -> m0_req_ready_o=1 same cycle; m0_resp_valid_o=1 with 0xDEADBEEF; m1_resp_valid_o stays 0.
- m0 and m1 both valid continuously, DM always ready -> accepts alternate m0,m1,m0,m1. Responses 0x1..0x4 return to m0,m1,m0,m1 respectively.
- m1 valid, dmi_req_ready_i=0 for 3 cycles, m0 asserts valid in cycle 2 -> grant held on m1. m1 is accepted in cycle 4 and m0 in cycle 5.
- MaxOutstanding=2, two accepted requests with no response -> the third is blocked (ready_o=0). After one response pops, the third is accepted the next cycle.
- Head=m1, m1_resp_ready_i=0 for 2 cycles -> dmi_resp_ready_o=0 and the FIFO holds. Pop happens on the cycle m1_resp_ready_i=1.
- Empty FIFO, dmi_resp_valid_i=1 -> dmi_resp_ready_o=1, spurious_resp_o pulses one cycle later, no m*_resp_valid_o. Also: rst_ni low with 2 outstanding -> FIFO empty, the next response is flagged spurious.
